// File: rtl/csh_cyc_arb_pkg.sv
// Shared types and defaults for the MBOX cache cycle arbiter/sequencer.
package csh_cyc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } csh_arb_state_t;

  localparam int CSH_NREQ      = 4;
  localparam int CSH_TSTEPS    = 4;
  localparam int CSH_RETRY_MAX = 7;

  localparam int CSH_SRC_MB   = 0;
  localparam int CSH_SRC_CHAN = 1;
  localparam int CSH_SRC_EBOX = 2;
  localparam int CSH_SRC_CCA  = 3;

endpackage

// File: rtl/csh_cyc_arb_if.sv
// Request/grant and timing-chain signals between the cache requestors and the cycle arbiter.
interface csh_cyc_arb_if #(
  parameter int NREQ      = 4,
  parameter int TSTEPS    = 4,
  parameter int RETRY_MAX = 7
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(RETRY_MAX + 1);

  logic [NREQ-1:0]   REQ;
  logic [NREQ-1:0]   REQ_EN;
  logic              CYC_HOLD;
  logic              ABORT;
  logic              DONE;
  logic              RETRY;
  logic [NREQ-1:0]   GRANT;
  logic [NREQ-1:0]   CYC;
  logic [TSTEPS-1:0] T;
  logic [IW-1:0]     CUR_IDX;
  logic              CACHE_IDLE;
  logic [CW-1:0]     RETRY_CNT;
  logic              RETRY_ERR;

  modport master (
    output REQ, REQ_EN, CYC_HOLD, ABORT, DONE, RETRY,
    input  GRANT, CYC, T, CUR_IDX, CACHE_IDLE, RETRY_CNT, RETRY_ERR
  );

  modport slave (
    input  REQ, REQ_EN, CYC_HOLD, ABORT, DONE, RETRY,
    output GRANT, CYC, T, CUR_IDX, CACHE_IDLE, RETRY_CNT, RETRY_ERR
  );
endinterface

// File: rtl/csh_pick.sv
// Combinational priority picker: retry override, then idx 0, then idx 1..NREQ-1
// (fixed low-index-first, or rotating from ptr when CSH_RR_ARB_EN is defined).
module csh_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] elig,
`ifdef CSH_RR_ARB_EN
  input  logic [IW-1:0]   ptr,
`endif
  input  logic            rp_vld,
  input  logic [IW-1:0]   rp_idx,
  output logic            win_vld,
  output logic            rp_hit,
  output logic [IW-1:0]   win_idx,
  output logic [NREQ-1:0] win_oh
);

  always_comb begin
    win_vld = |elig;
    rp_hit  = 1'b0;
    win_idx = '0;
    if (rp_vld && elig[rp_idx]) begin
      rp_hit  = 1'b1;
      win_idx = rp_idx;
    end else if (elig[0]) begin
      win_idx = '0;
    end else begin
`ifdef CSH_RR_ARB_EN
      // Scan backwards so the source closest to ptr is the last writer.
      for (int k = NREQ - 2; k >= 0; k--) begin
        if (elig[((int'(ptr) - 1 + k) % (NREQ - 1)) + 1])
          win_idx = IW'(((int'(ptr) - 1 + k) % (NREQ - 1)) + 1);
      end
`else
      for (int i = NREQ - 1; i >= 1; i--) begin
        if (elig[i]) win_idx = IW'(i);
      end
`endif
    end
    win_oh = win_vld ? (NREQ'(1) << win_idx) : '0;
  end

endmodule

// File: rtl/csh_cyc_arb.sv
// MBOX cache cycle arbiter/sequencer: grant, latch cycle type, run T0..T[TSTEPS-1] to DONE/ABORT/RETRY.
// Optional rotating priority among idx 1..NREQ-1 under CSH_RR_ARB_EN; fixed priority otherwise.
module csh_cyc_arb
  import csh_cyc_arb_pkg::*;
#(
  parameter int NREQ      = CSH_NREQ,
  parameter int TSTEPS    = CSH_TSTEPS,
  parameter int RETRY_MAX = CSH_RETRY_MAX
) (
  input  logic          clk,
  input  logic          RESET,
  csh_cyc_arb_if.slave  bus
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(RETRY_MAX + 1);
  localparam int T1 = (TSTEPS > 1) ? 1 : 0;

  csh_arb_state_t    state, state_nxt;
  logic [NREQ-1:0]   cyc, grant;
  logic [TSTEPS-1:0] t, t_sh;
  logic [IW-1:0]     cur_idx, rp_idx, win_idx;
  logic [CW-1:0]     retry_cnt;
  logic              retry_err, rp_vld;
  logic              win_vld, rp_hit;
  logic [NREQ-1:0]   win_oh;
  logic              do_grant, do_retry, do_done;
`ifdef CSH_RR_ARB_EN
  logic [IW-1:0]     rot_ptr;
`endif

  csh_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .elig    (bus.REQ & bus.REQ_EN),
`ifdef CSH_RR_ARB_EN
    .ptr     (rot_ptr),
`endif
    .rp_vld  (rp_vld),
    .rp_idx  (rp_idx),
    .win_vld (win_vld),
    .rp_hit  (rp_hit),
    .win_idx (win_idx),
    .win_oh  (win_oh)
  );

  assign t_sh = t << 1;

  // RETRY outranks DONE, which outranks ABORT; ABORT only counts at T1 while still running.
  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    do_retry  = 1'b0;
    do_done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!bus.CYC_HOLD && win_vld) begin
          do_grant  = 1'b1;
          state_nxt = (TSTEPS == 1) ? WAIT : RUN;
        end
      end
      RUN: begin
        if (bus.RETRY) begin
          do_retry  = 1'b1;
          state_nxt = IDLE;
        end else if (bus.DONE) begin
          do_done   = 1'b1;
          state_nxt = IDLE;
        end else if ((TSTEPS > 1) && bus.ABORT && t[T1]) begin
          state_nxt = IDLE;
        end else if (t_sh[TSTEPS-1]) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (bus.RETRY) begin
          do_retry  = 1'b1;
          state_nxt = IDLE;
        end else if (bus.DONE) begin
          do_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state     <= IDLE;
      cyc       <= '0;
      grant     <= '0;
      t         <= '0;
      cur_idx   <= '0;
      retry_cnt <= '0;
      retry_err <= 1'b0;
      rp_vld    <= 1'b0;
      rp_idx    <= '0;
`ifdef CSH_RR_ARB_EN
      rot_ptr   <= IW'(1);
`endif
    end else begin
      state <= state_nxt;
      grant <= '0;
      if (do_grant) begin
        cyc     <= win_oh;
        grant   <= win_oh;
        t       <= TSTEPS'(1);
        cur_idx <= win_idx;
        if (!rp_hit) rp_vld <= 1'b0;
`ifdef CSH_RR_ARB_EN
        if (!rp_hit && win_idx != '0)
          rot_ptr <= (win_idx == IW'(NREQ - 1)) ? IW'(1) : win_idx + IW'(1);
`endif
      end else if (state != IDLE && state_nxt == IDLE) begin
        cyc     <= '0;
        t       <= '0;
        cur_idx <= '0;
      end else if (state == RUN) begin
        t <= t_sh;
      end
      if (do_retry) begin
        rp_vld <= 1'b1;
        rp_idx <= cur_idx;
        if (retry_cnt != CW'(RETRY_MAX)) retry_cnt <= retry_cnt + CW'(1);
        if (retry_cnt >= CW'(RETRY_MAX - 1)) retry_err <= 1'b1;
      end
      if (do_done) begin
        retry_cnt <= '0;
        rp_vld    <= 1'b0;
      end
    end
  end

  assign bus.GRANT      = grant;
  assign bus.CYC        = cyc;
  assign bus.T          = t;
  assign bus.CUR_IDX    = cur_idx;
  assign bus.CACHE_IDLE = (state == IDLE);
  assign bus.RETRY_CNT  = retry_cnt;
  assign bus.RETRY_ERR  = retry_err;

endmodule

// File: tb/tb_csh_cyc_arb.sv
// Directed bench for csh_cyc_arb (NREQ=4, TSTEPS=4, RETRY_MAX=7) with hand-computed expectations.
module tb_csh_cyc_arb;

  logic clk = 1'b0;
  logic RESET;
  int   n_vec = 0;
  int   n_bad = 0;

  csh_cyc_arb_if #(.NREQ(4), .TSTEPS(4), .RETRY_MAX(7)) bus ();

  csh_cyc_arb #(.NREQ(4), .TSTEPS(4), .RETRY_MAX(7)) dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_idle"},  32'(bus.CACHE_IDLE), 32'h1);
    chk({tag, "_grant"}, 32'(bus.GRANT),      32'h0);
    chk({tag, "_cyc"},   32'(bus.CYC),        32'h0);
    chk({tag, "_t"},     32'(bus.T),          32'h0);
    chk({tag, "_idx"},   32'(bus.CUR_IDX),    32'h0);
    chk({tag, "_rcnt"},  32'(bus.RETRY_CNT),  32'h0);
    chk({tag, "_rerr"},  32'(bus.RETRY_ERR),  32'h0);
  endtask

  logic [3:0] rr_exp [4];

  initial begin
    RESET = 1'b1;
    bus.REQ = '0; bus.REQ_EN = 4'b1111; bus.CYC_HOLD = 1'b0;
    bus.ABORT = 1'b0; bus.DONE = 1'b0; bus.RETRY = 1'b0;
    tick(); tick();
    RESET = 1'b0;
    chk_reset("rst");

    // 1: basic grant, timing chain, hold at last step, DONE
    bus.REQ = 4'b1010;
    tick();
    chk("t1_grant", 32'(bus.GRANT), 32'h2);
    chk("t1_cyc",   32'(bus.CYC),   32'h2);
    chk("t1_t0",    32'(bus.T),     32'h1);
    chk("t1_idx",   32'(bus.CUR_IDX), 32'h1);
    bus.REQ = '0;
    tick();
    chk("t1_gpulse", 32'(bus.GRANT), 32'h0);
    chk("t1_t1",     32'(bus.T),     32'h2);
    tick(); tick();
    chk("t1_t3",   32'(bus.T), 32'h8);
    tick();
    chk("t1_hold", 32'(bus.T), 32'h8);
    chk("t1_cycb", 32'(bus.CYC), 32'h2);
    bus.DONE = 1'b1;
    tick();
    bus.DONE = 1'b0;
    chk("t1_done_idle", 32'(bus.CACHE_IDLE), 32'h1);
    chk("t1_done_t",    32'(bus.T),          32'h0);

    // 2: ABORT at T1 honoured, at T2 ignored
    bus.REQ = 4'b0100;
    tick();
    bus.REQ = '0;
    tick();
    chk("t2_at_t1", 32'(bus.T), 32'h2);
    bus.ABORT = 1'b1;
    tick();
    bus.ABORT = 1'b0;
    chk("t2_abort_idle", 32'(bus.CACHE_IDLE), 32'h1);
    chk("t2_abort_cnt",  32'(bus.RETRY_CNT),  32'h0);
    bus.REQ = 4'b0100;
    tick();
    bus.REQ = '0;
    tick(); tick();
    chk("t2_at_t2", 32'(bus.T), 32'h4);
    bus.ABORT = 1'b1;
    tick();
    bus.ABORT = 1'b0;
    chk("t2_ign_idle", 32'(bus.CACHE_IDLE), 32'h0);
    chk("t2_ign_t",    32'(bus.T),          32'h8);
    bus.DONE = 1'b1;
    tick();
    bus.DONE = 1'b0;

    // 3: RETRY in WAIT, re-grant of idx2 over idx0/idx1, DONE clears count
    bus.REQ = 4'b0100;
    tick();
    chk("t3_cyc", 32'(bus.CYC), 32'h4);
    bus.REQ = '0;
    tick(); tick(); tick();
    bus.REQ = 4'b0111;
    bus.RETRY = 1'b1;
    tick();
    bus.RETRY = 1'b0;
    chk("t3_retry_idle", 32'(bus.CACHE_IDLE), 32'h1);
    chk("t3_retry_cnt",  32'(bus.RETRY_CNT),  32'h1);
    tick();
    chk("t3_regrant", 32'(bus.GRANT), 32'h4);
    bus.REQ = '0;
    bus.DONE = 1'b1;
    tick();
    bus.DONE = 1'b0;
    chk("t3_done_cnt", 32'(bus.RETRY_CNT), 32'h0);

    // 4: seven consecutive retries on idx3, sticky error, RESET clears
    bus.REQ = 4'b1000;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("t4_grant%0d", i), 32'(bus.GRANT), 32'h8);
      bus.RETRY = 1'b1;
      tick();
      bus.RETRY = 1'b0;
      chk($sformatf("t4_cnt%0d", i), 32'(bus.RETRY_CNT), 32'(i + 1));
      chk($sformatf("t4_err%0d", i), 32'(bus.RETRY_ERR), (i == 6) ? 32'h1 : 32'h0);
    end
    tick();
    bus.REQ = '0;
    bus.DONE = 1'b1;
    tick();
    bus.DONE = 1'b0;
    chk("t4_done_cnt",  32'(bus.RETRY_CNT), 32'h0);
    chk("t4_sticky",    32'(bus.RETRY_ERR), 32'h1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("t4_rst_err", 32'(bus.RETRY_ERR), 32'h0);
    chk("t4_rst_cnt", 32'(bus.RETRY_CNT), 32'h0);

    // 5: RETRY+DONE together is a retry; CYC_HOLD blocks grants
    bus.REQ = 4'b0010;
    tick();
    bus.REQ = '0;
    bus.RETRY = 1'b1; bus.DONE = 1'b1;
    tick();
    bus.RETRY = 1'b0; bus.DONE = 1'b0;
    chk("t5_both_cnt",  32'(bus.RETRY_CNT),  32'h1);
    chk("t5_both_idle", 32'(bus.CACHE_IDLE), 32'h1);
    bus.CYC_HOLD = 1'b1;
    bus.REQ = 4'b1111;
    tick();
    chk("t5_hold_g1", 32'(bus.GRANT), 32'h0);
    tick();
    chk("t5_hold_g2",   32'(bus.GRANT),      32'h0);
    chk("t5_hold_idle", 32'(bus.CACHE_IDLE), 32'h1);
    bus.CYC_HOLD = 1'b0;
    tick();
    chk("t5_release", 32'(bus.GRANT), 32'h2);
    bus.REQ = '0;
    bus.DONE = 1'b1;
    tick();
    bus.DONE = 1'b0;
    chk("t5_done_cnt", 32'(bus.RETRY_CNT), 32'h0);

    // 6: arbitration order with REQ=1110 held, then RESET mid-cycle
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
`ifdef CSH_RR_ARB_EN
    rr_exp[0] = 4'b0010; rr_exp[1] = 4'b0100; rr_exp[2] = 4'b1000; rr_exp[3] = 4'b0010;
`else
    rr_exp[0] = 4'b0010; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0010; rr_exp[3] = 4'b0010;
`endif
    bus.REQ = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t6_grant%0d", i), 32'(bus.GRANT), 32'(rr_exp[i]));
      bus.DONE = 1'b1;
      tick();
      bus.DONE = 1'b0;
    end
    tick();
    bus.REQ = '0;
    tick(); tick();
    chk("t6_at_t2", 32'(bus.T), 32'h4);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk_reset("t6_rst");
    tick();
    chk("t6_stay_idle", 32'(bus.CACHE_IDLE), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
